cliff_responder: RTL
====================

Name: cliff_responder

Overview:
- Target-side responder for the rd/ws read-handshake used by the cliff initiator FSM.
- Samples the initiator's rd strobe and inserts a programmable number of wait states on ws.
- Presents one read-data word per completed transaction.
- Sits between the cliff initiator and a simple data source; also used as the bench-side model of the slow peripheral.

Parameters:
- DATA_W, 8, width of rdata.
- WAIT_W, 4, width of wait_cfg and the wait-state counter.
- DATA_INIT, 8'hA0, first rdata value after reset.
- CNT_W, 8, width of txn_count.

Ports:
- clk  input  1  single clock; everything updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd  input  1  read request from initiator, level, held for the whole transaction.
- wait_cfg  input  WAIT_W  wait states for the next transaction; sampled only at acceptance.
- ws  output  1  wait-state indication to initiator; registered.
- rdata  output  DATA_W  read data; valid only while rvalid=1; registered.
- rvalid  output  1  one-cycle data-valid pulse; registered.
- busy  output  1  high in any state other than IDLE.
- abort_err  output  1  sticky: rd dropped while ws was asserted.
- txn_count  output  CNT_W  completed transactions; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports are clk and rst.
- Reset, on the rising edge with rst=1:
  - state=IDLE, ws=0, rvalid=0, busy=0, abort_err=0, txn_count=0.
  - rdata=0; data pointer=DATA_INIT.
  - Reset overrides everything, including mid-transaction; ws drops the cycle after reset is sampled.
- States: IDLE, WAIT, DATA, HOLD. All outputs are registered from next-state and next-counter logic, so there are no combinational paths from inputs to outputs.
- IDLE:
  - rd=1 sampled with wait_cfg=0: go to DATA; ws stays 0.
  - rd=1 sampled with wait_cfg=N>0: go to WAIT; load cnt=N; ws=1 from the next cycle.
- WAIT:
  - ws=1 for exactly N consecutive cycles.
  - cnt decrements each cycle; when cnt==1 with rd=1, go to DATA and ws=0.
  - rd=0 in WAIT: go to IDLE, ws=0 the next cycle, set abort_err.
  - An aborted transaction does not bump txn_count or the data pointer.
- DATA (one cycle):
  - rvalid=1, rdata=pointer.
  - Pointer increments by 1, wrapping at 2^DATA_W. txn_count increments, wrapping.
  - Next state is HOLD.
  - rd=0 in DATA still completes the transaction.
- HOLD:
  - Stay while rd=1; go to IDLE on rd=0.
  - rd must be seen low for at least one cycle before a new request is accepted; this blocks re-triggering on a held rd.
- Latency: rd rising edge sampled at edge k → rvalid at edge k+1+N.
- rdata holds its last value outside DATA.
- wait_cfg changes during WAIT are ignored.
- abort_err clears only on rst.

Test Plan:
- Reset → rst=1 for 5 cycles, then release → ws=0, rvalid=0, busy=0, txn_count=0; first read returns 8'hA0.
- Zero wait → wait_cfg=0, rd=1 for 3 cycles, then 0 → ws never high; rvalid for exactly one cycle with rdata=A0; txn_count=1; idle after rd drops.
- Wait states → wait_cfg=3, rd held → ws high for exactly 3 cycles; rvalid on the 4th cycle after acceptance with rdata=A1; txn_count=2.
- Back-to-back → rd held across 2 cycles after rvalid, then pulsed low 1 cycle, then high again with wait_cfg=1 → no second rvalid until rd returns; then ws=1 for 1 cycle and rdata=A2.
- Abort → wait_cfg=5, rd drops on the 2nd ws cycle → ws=0 next cycle, abort_err=1 and stays; txn_count unchanged; the next good read returns the unconsumed pointer value.
- Mid-op reset and wrap → assert rst during WAIT → ws=0, abort_err=0 next cycle. Then 256 reads → txn_count wraps to 0; rdata wraps FF→00.

Source files
------------

// File: rtl/cliff_responder.sv
// Target-side responder for the rd/ws read handshake: inserts programmable wait states and
// returns one data word per completed transaction.
module cliff_responder #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       WAIT_W    = 4,
   parameter logic [DATA_W-1:0] DATA_INIT = 8'hA0,
   parameter int unsigned       CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic [WAIT_W-1:0] wait_cfg,
   output logic              ws,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              abort_err,
   output logic [CNT_W-1:0]  txn_count
);

   typedef enum logic [1:0] {StIdle, StWait, StData, StHold} state_e;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [CNT_W-1:0]    txn_q, txn_d;
   logic                ws_q, ws_d;
   logic                rvalid_q, rvalid_d;
   logic                abort_q, abort_d;
   logic                enter_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      unique case (state_q)
         StIdle: begin
            if (rd) begin
               if (wait_cfg == '0) begin
                  state_d = StData;
               end else begin
                  state_d = StWait;
                  cnt_d   = wait_cfg;
               end
            end
         end
         StWait: begin
            // rd is checked before the counter so a late drop still aborts
            if (!rd) begin
               state_d = StIdle;
               abort_d = 1'b1;
            end else begin
               cnt_d = cnt_q - WAIT_W'(1);
               if (cnt_q == WAIT_W'(1)) begin
                  state_d = StData;
               end
            end
         end
         StData: state_d = StHold;
         StHold: begin
            if (!rd) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // DATA lasts exactly one cycle, so state_d == StData marks a single entry
      enter_data = (state_d == StData);
      ws_d       = (state_d == StWait);
      rvalid_d   = enter_data;
      rdata_d    = enter_data ? ptr_q : rdata_q;
      ptr_d      = enter_data ? ptr_q + DATA_W'(1) : ptr_q;
      txn_d      = enter_data ? txn_q + CNT_W'(1) : txn_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ptr_q    <= DATA_INIT;
         rdata_q  <= '0;
         txn_q    <= '0;
         ws_q     <= 1'b0;
         rvalid_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         rdata_q  <= rdata_d;
         txn_q    <= txn_d;
         ws_q     <= ws_d;
         rvalid_q <= rvalid_d;
         abort_q  <= abort_d;
      end
   end

   assign ws        = ws_q;
   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign busy      = (state_q != StIdle);
   assign abort_err = abort_q;
   assign txn_count = txn_q;

endmodule
